softmax_max_subtract_serializer: RTL
====================================

Name: softmax_max_subtract_serializer

Overview:
- Consumer-side partner of the softmax max-reduction tree.
- Captures a 32-element signed vector, waits for the matching maximum from the reduction pipeline, then streams x[i] - max one element per beat to the exponent stage.
- The output stream uses a valid/ready handshake with backpressure.
- Sits between the vector source / max reduction tree and the serial exp/LUT unit of the 32-element softmax.

Parameters:
- BIT_WIDTH, 16, signed element width of input vector, max value and output difference
- N, 32, vector length (power of two, >= 2)
- IDX_W, $clog2(N), element index counter width

Ports:
- i_clk  input  1  clock, rising edge
- i_rst  input  1  reset, asynchronous, active-high
- i_valid  input  1  input vector valid
- o_ready  output  1  block can accept a vector this cycle
- i_data  input  N x BIT_WIDTH signed  input vector, element 0 streamed first
- i_max_valid  input  1  maximum for the captured vector is present on i_max
- i_max  input  BIT_WIDTH signed  vector maximum from the reduction tree
- o_valid  output  1  output element valid
- i_ready  input  1  downstream accepts output element
- o_data  output  BIT_WIDTH signed  saturated x[idx] - max
- o_idx  output  IDX_W  index of element on o_data
- o_last  output  1  high with element N-1
- o_busy  output  1  high in WAIT_MAX or STREAM
- o_err  output  1  one-cycle pulse on protocol violation

Behaviour:
- Reset, asynchronous, when i_rst high:
  - state=IDLE, o_ready=1, o_valid=0, o_last=0, o_idx=0, o_data=0, o_busy=0, o_err=0.
  - Buffer contents don't-care.
- FSM states: IDLE, WAIT_MAX, STREAM.
- IDLE:
  - o_ready=1.
  - i_valid=1 captures all N elements into the buffer and moves to WAIT_MAX.
- WAIT_MAX:
  - o_ready=0.
  - i_max_valid=1 registers i_max, clears idx to 0, moves to STREAM.
  - Waits indefinitely otherwise; no timeout.
- Same-cycle vector and max: if i_max_valid and i_valid are both high in IDLE, the vector is captured, the max is ignored and o_err pulses. The max must arrive at least 1 cycle after capture; the tree delivers it log2(N) cycles later.
- STREAM:
  - o_valid=1, o_data = sat(buf[idx] - max), o_idx=idx, o_last=(idx==N-1).
  - A handshake (o_valid & i_ready) advances idx by 1.
  - A handshake with o_last=1 returns to IDLE; o_ready is high the next cycle.
  - i_ready=0 holds o_data/o_idx/o_last stable, with no change until accepted.
- Output timing: outputs are registered. The first o_valid appears in the cycle after i_max_valid is sampled. Throughput is 1 element/cycle with i_ready held high. Vector-to-vector minimum is N+2 cycles plus the max latency.
- Arithmetic:
  - Compute in BIT_WIDTH+1 signed bits.
  - Clamp the result to [-(2^(BIT_WIDTH-1)), 2^(BIT_WIDTH-1)-1].
  - A correct max gives a result <= 0. A positive result (max not the true max) is passed through clamped, not flagged.
- o_err pulses for one cycle when:
  - i_max_valid is high in IDLE, or
  - i_max_valid is high in STREAM.
  The offending max is dropped and state is unaffected.
- Ignored inputs: i_valid in WAIT_MAX/STREAM is ignored (o_ready=0). The upstream must hold the vector until o_ready.
- Reset mid-operation: an asynchronous reset in WAIT_MAX or STREAM aborts immediately to IDLE; partial streams are not resumed.
- o_busy = (state != IDLE).

Test Plan:
- Basic vector: data[i]=i (0..31), max 31 delivered 5 cycles after capture -> 32 beats o_data = -31,-30,...,0; o_idx 0..31; o_last only on beat 31; o_ready returns 1 after the last beat.
- Saturation: BIT_WIDTH=16, data[0]=-32768, data[1..31]=32767, max=32767 -> o_data[0]=-32768 (clamped from -65535), others 0.
- Backpressure: i_ready toggling 1,0,0,1 through the stream -> o_data/o_idx held during low cycles, no beat lost or duplicated, 32 accepted beats total.
- Protocol errors: i_max_valid pulsed in IDLE, then again in STREAM at idx=10 -> o_err pulses each time, stream values unchanged, state unaffected.
- Back-to-back vectors: i_valid held with vector A then vector B, i_ready=1 -> B accepted only in the cycle o_ready rises after A's last beat; B's stream uses B's max.
- Reset mid-stream: assert i_rst at idx=7 -> o_valid=0 and o_ready=1 immediately; the next vector streams from idx 0.

Source files
------------

// File: rtl/softmax_max_subtract_serializer.sv
// Buffers one N-element signed vector, waits for its maximum, then streams
// saturated x[i] - max one element per accepted beat with valid/ready.
module softmax_max_subtract_serializer #(
  parameter int BIT_WIDTH = 16,
  parameter int N         = 32,
  parameter int IDX_W     = $clog2(N)
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  input  logic                           i_valid,
  output logic                           o_ready,
  input  logic [N-1:0][BIT_WIDTH-1:0]    i_data,
  input  logic                           i_max_valid,
  input  logic signed [BIT_WIDTH-1:0]    i_max,
  output logic                           o_valid,
  input  logic                           i_ready,
  output logic signed [BIT_WIDTH-1:0]    o_data,
  output logic [IDX_W-1:0]               o_idx,
  output logic                           o_last,
  output logic                           o_busy,
  output logic                           o_err
);

  typedef enum logic [1:0] {IDLE, WAIT_MAX, STREAM} state_t;

  localparam logic signed [BIT_WIDTH-1:0] SAT_MAX = {1'b0, {(BIT_WIDTH-1){1'b1}}};
  localparam logic signed [BIT_WIDTH-1:0] SAT_MIN = {1'b1, {(BIT_WIDTH-1){1'b0}}};
  localparam logic [IDX_W-1:0]            LAST_IDX = IDX_W'(N - 1);

  state_t                       state_q, state_d;
  logic signed [BIT_WIDTH-1:0]  max_q, max_d;
  logic                         valid_q, valid_d;
  logic signed [BIT_WIDTH-1:0]  data_q, data_d;
  logic [IDX_W-1:0]             idx_q, idx_d;
  logic                         last_q, last_d;
  logic                         ready_q, ready_d;
  logic                         busy_q, busy_d;
  logic                         err_q, err_d;
  logic                         capture;
  logic [N-1:0][BIT_WIDTH-1:0]  vec_q;

  // One extra bit of headroom, then clamp back to BIT_WIDTH.
  function automatic logic signed [BIT_WIDTH-1:0] sat_sub(
    input logic signed [BIT_WIDTH-1:0] a,
    input logic signed [BIT_WIDTH-1:0] b
  );
    logic [BIT_WIDTH:0] diff;
    diff = {a[BIT_WIDTH-1], a} - {b[BIT_WIDTH-1], b};
    if (diff[BIT_WIDTH] != diff[BIT_WIDTH-1]) begin
      return diff[BIT_WIDTH] ? SAT_MIN : SAT_MAX;
    end
    return diff[BIT_WIDTH-1:0];
  endfunction

  always_comb begin
    state_d = state_q;
    max_d   = max_q;
    valid_d = valid_q;
    data_d  = data_q;
    idx_d   = idx_q;
    last_d  = last_q;
    err_d   = 1'b0;
    capture = 1'b0;
    case (state_q)
      IDLE: begin
        // A max arriving here has no vector to belong to; flag and drop it.
        err_d = i_max_valid;
        if (i_valid) begin
          capture = 1'b1;
          state_d = WAIT_MAX;
        end
      end
      WAIT_MAX: begin
        if (i_max_valid) begin
          max_d   = i_max;
          state_d = STREAM;
          valid_d = 1'b1;
          idx_d   = '0;
          data_d  = sat_sub(vec_q[0], i_max);
          last_d  = 1'b0;
        end
      end
      STREAM: begin
        err_d = i_max_valid;
        if (valid_q && i_ready) begin
          if (last_q) begin
            state_d = IDLE;
            valid_d = 1'b0;
            last_d  = 1'b0;
            idx_d   = '0;
            data_d  = '0;
          end else begin
            idx_d  = idx_q + 1'b1;
            data_d = sat_sub(vec_q[idx_d], max_q);
            last_d = (idx_d == LAST_IDX);
          end
        end
      end
      default: state_d = IDLE;
    endcase
    ready_d = (state_d == IDLE);
    busy_d  = (state_d != IDLE);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
      max_q   <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
      idx_q   <= '0;
      last_q  <= 1'b0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      max_q   <= max_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
    end
  end

  // Vector storage needs no reset: it is always written before it is read.
  always_ff @(posedge i_clk) begin
    if (capture) begin
      vec_q <= i_data;
    end
  end

  assign o_ready = ready_q;
  assign o_valid = valid_q;
  assign o_data  = data_q;
  assign o_idx   = idx_q;
  assign o_last  = last_q;
  assign o_busy  = busy_q;
  assign o_err   = err_q;

endmodule
